// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and bus dimensions
// Purpose: types and constants shared by the APB master bridge and the apb_dut bench.
// Contents: apb_state_e (IDLE/SETUP/ACCESS), APB_ADDR_W, APB_DATA_W, APB_MEM_WORDS.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W    = 32;
  localparam int APB_DATA_W    = 32;
  localparam int APB_MEM_WORDS = 32;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-command APB requester with timeout and one-entry response slot
// Purpose: accepts one read/write command at a time, runs APB SETUP/ACCESS, waits for PREADY
//          (bounded by TIMEOUT_CYCLES, 0 = unbounded) and returns the result on a held response.
// Ports:   PCLK/PRESET          clock, async active-high reset
//          cmd_valid/cmd_ready  command handshake; cmd_write/cmd_addr/cmd_wdata payload
//          rsp_valid/rsp_ready  response handshake; rsp_rdata/rsp_err/rsp_timeout payload
//          PSEL/PENABLE/PWRITE/PADDR/PWDATA  registered APB request
//          PRDATA/PREADY/PSLVERR             APB completion inputs (sampled in ACCESS only)
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // A new command may start only once the response slot is free or being freed this edge,
  // so a completion can never overwrite an unconsumed response.
  assign cmd_ready = !PRESET && (state_q == APB_IDLE) && (!rsp_valid_q || rsp_ready);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      APB_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = APB_SETUP;
        end
      end
      APB_SETUP: begin
        penable_d = 1'b1;
        state_d   = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          state_d       = APB_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = APB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = APB_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= APB_IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge with a transaction-level model
module tb_apb_master_bridge;

  localparam int T     = 4;
  localparam int WORDS = 32;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired act=0 exp=1", name);
  endtask

  // rsp_ready: fixed level or a fresh random bit every cycle
  bit rr_mode = 1'b0;
  bit rr_fixed = 1'b1;
  bit rr_rand = 1'b0;
  assign rsp_ready = rr_mode ? rr_rand : rr_fixed;
  initial forever begin
    @(posedge PCLK); #1;
    rr_rand = 1'($urandom_range(0, 1));
  end

  // Slave: 32-word memory, PREADY after slave_wait ACCESS cycles, error above the memory
  logic [31:0] slave_mem [WORDS];
  bit          slave_init = 1'b0;
  int          slave_wait = 0;
  int          acc_cnt = 0;
  assign PREADY  = PSEL && PENABLE && (acc_cnt >= slave_wait);
  assign PSLVERR = PSEL && PENABLE && (PADDR >= 32'(WORDS));
  assign PRDATA  = (PADDR < 32'(WORDS)) ? slave_mem[PADDR[4:0]] : '0;
  always @(posedge PCLK) begin
    if (!slave_init) begin
      for (int i = 0; i < WORDS; i++) slave_mem[i] <= 32'h1000_0000 + 32'(i);
      slave_init <= 1'b1;
    end else if (PSEL && PENABLE && PREADY && PWRITE && (PADDR < 32'(WORDS))) begin
      slave_mem[PADDR[4:0]] <= PWDATA;
    end
    acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
  end

  // Transaction model: each accepted command occupies edges [start, end) with PSEL high,
  // end = start + 2 + waits, or start + 2 + (T-1) when the slave never answers in time.
  logic [31:0] ref_mem [WORDS];
  int          m_e = 0, m_s = 0, m_end = 0, acc_count = 0;
  bit          m_busy = 0, m_pend = 0;
  bit          t_write = 0, t_to = 0;
  logic [31:0] t_addr = '0, t_data = '0;
  logic [31:0] last_addr = '0, last_data = '0;
  bit          last_write = 0;
  logic [31:0] p_rdata = '0;
  bit          p_err = 0, p_to = 0;

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    forever begin
      @(posedge PCLK or posedge PRESET);
      if (PRESET) begin
        m_busy = 0; m_pend = 0; m_e = 0;
        last_addr = '0; last_data = '0; last_write = 0;
      end else begin
        bit can_take;
        can_take = !m_busy && (!m_pend || rsp_ready);
        m_e++;
        if (m_pend && rsp_ready) m_pend = 0;
        if (m_busy && m_e == m_end) begin
          m_busy = 0;
          m_pend = 1;
          if (t_to) begin
            p_rdata = '0; p_err = 1; p_to = 1;
          end else begin
            p_err   = (t_addr >= 32'(WORDS));
            p_to    = 0;
            p_rdata = (t_write || p_err) ? '0 : ref_mem[t_addr[4:0]];
            if (t_write && !p_err) ref_mem[t_addr[4:0]] = t_data;
          end
        end
        if (cmd_valid && can_take) begin
          m_busy = 1; m_s = m_e;
          t_write = cmd_write; t_addr = cmd_addr; t_data = cmd_wdata;
          t_to  = (slave_wait >= T);
          m_end = m_e + 2 + (t_to ? T - 1 : slave_wait);
          last_addr = cmd_addr; last_data = cmd_wdata; last_write = cmd_write;
          acc_count++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge PCLK);
    chk("cmd_ready", 32'(cmd_ready), 32'(!PRESET && !m_busy && (!m_pend || rsp_ready)));
    chk("psel", 32'(PSEL), 32'(m_busy));
    chk("penable", 32'(PENABLE), 32'(m_busy && (m_e > m_s)));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    chk("paddr", PADDR, last_addr);
    chk("pwdata", PWDATA, last_data);
    chk("pwrite", 32'(PWRITE), 32'(last_write));
    if (m_pend) begin
      chk("rsp_rdata", rsp_rdata, p_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(p_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(p_to));
    end
  end

  int acc_base = 0;

  task automatic present(input bit w, input logic [31:0] a, input logic [31:0] d, input int wt);
    @(posedge PCLK); #1;
    slave_wait = wt;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    acc_base = acc_count;
  endtask

  task automatic wait_accept();
    int n;
    for (n = 0; n < 50; n++) begin
      @(posedge PCLK); #1;
      if (acc_count != acc_base) break;
    end
    cmd_valid = 1'b0;
    if (n == 50) bound_fail("wait_accept");
  endtask

  task automatic wait_rsp();
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge PCLK);
      if (rsp_valid) break;
    end
    if (n == 60) bound_fail("wait_rsp");
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 100; n++) begin
      if (!m_busy) break;
      @(posedge PCLK); #1;
    end
    if (n == 100) bound_fail("wait_idle");
  endtask

  initial begin
    int pen_cycles;
    // reset state
    repeat (2) @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // 1: zero-wait write, exact cycle positions
    present(1'b1, 32'h5, 32'hDEADBEEF, 0);
    wait_accept();
    @(negedge PCLK);
    chk("t1_psel_setup", 32'(PSEL), 32'd1);
    chk("t1_penable_setup", 32'(PENABLE), 32'd0);
    @(negedge PCLK);
    chk("t1_penable_access", 32'(PENABLE), 32'd1);
    chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    chk("t1_rsp_rdata", rsp_rdata, 32'd0);
    chk("t1_psel_done", 32'(PSEL), 32'd0);

    // 2: read back with waits
    present(1'b0, 32'h5, 32'h0, 2);
    wait_accept();
    @(negedge PCLK);
    chk("t2_pwrite", 32'(PWRITE), 32'd0);
    wait_rsp();
    chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t2_rsp_err", 32'(rsp_err), 32'd0);

    // 3: slave error
    present(1'b1, 32'h40, 32'h1234, 0);
    wait_accept();
    wait_rsp();
    chk("t3_rsp_err", 32'(rsp_err), 32'd1);
    chk("t3_rsp_timeout", 32'(rsp_timeout), 32'd0);

    // 4: timeout after T ACCESS cycles
    present(1'b0, 32'h7, 32'h0, 1000);
    wait_accept();
    pen_cycles = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge PCLK);
      if (PENABLE) pen_cycles++;
      if (rsp_valid) break;
    end
    chk("t4_access_cycles", 32'(pen_cycles), 32'd4);
    chk("t4_rsp_err", 32'(rsp_err), 32'd1);
    chk("t4_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("t4_rsp_rdata", rsp_rdata, 32'd0);
    chk("t4_psel", 32'(PSEL), 32'd0);

    // 5: held response blocks the next command; same-edge rsp+cmd handshake
    @(posedge PCLK); #1;
    rr_fixed = 1'b0;
    present(1'b1, 32'h1, 32'h0000_0011, 0);
    wait_accept();
    wait_rsp();
    present(1'b0, 32'h1, 32'h0, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge PCLK);
      chk("t5_cmd_ready_blocked", 32'(cmd_ready), 32'd0);
      chk("t5_psel_blocked", 32'(PSEL), 32'd0);
    end
    @(posedge PCLK); #1;
    rr_fixed = 1'b1;
    @(posedge PCLK); #1;
    chk("t5_same_edge_accept", 32'(acc_count - acc_base), 32'd1);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("t5_psel_next", 32'(PSEL), 32'd1);
    chk("t5_rsp_dropped", 32'(rsp_valid), 32'd0);
    wait_rsp();
    chk("t5_rsp_rdata", rsp_rdata, 32'h0000_0011);

    // 6: reset during ACCESS, then the same read completes normally
    present(1'b0, 32'h3, 32'h0, 3);
    wait_accept();
    @(negedge PCLK);
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk("t6_psel_async", 32'(PSEL), 32'd0);
    chk("t6_penable_async", 32'(PENABLE), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_paddr", PADDR, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    present(1'b0, 32'h3, 32'h0, 1);
    wait_accept();
    wait_rsp();
    chk("t6_rsp_rdata", rsp_rdata, 32'h1000_0003);
    chk("t6_rsp_err", 32'(rsp_err), 32'd0);

    // random traffic with random rsp_ready, waits and out-of-range addresses
    rr_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wait_idle();
      present(1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom, $urandom_range(0, 5));
      wait_accept();
    end
    wait_idle();
    rr_mode = 1'b0;
    rr_fixed = 1'b1;
    repeat (4) @(negedge PCLK);
    chk("end_rsp_drained", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
